// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - parametrised universal shift register with shift counter and word_done pulse (option: USR_ROTATE_EN)
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic             rot,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic [CW-1:0]    shift_cnt,
  output logic             word_done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  // Count value whose next shift completes a word.
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             fill_r;
  logic             fill_l;
  logic             shift_act;

`ifdef USR_ROTATE_EN
  // Serial fill bits: a rotate feeds back the bit leaving the opposite end.
  always_comb begin
    fill_r = ser_in_r;
    fill_l = ser_in_l;
    if (rot) begin
      fill_r = data_q[0];
      fill_l = data_q[WIDTH-1];
    end
  end
`else
  // Serial fill bits come straight from the serial inputs; rot is kept only
  // so both builds share one instance template.
  logic unused_rot;
  assign unused_rot = rot;

  always_comb begin
    fill_r = ser_in_r;
    fill_l = ser_in_l;
  end
`endif

  // Next-state: data path by mode, shift counter with wrap, word_done pulse.
  always_comb begin
    data_d    = data_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    shift_act = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
          data_d = data_q;
        end
        MODE_RIGHT: begin
          data_d    = {fill_r, data_q[WIDTH-1:1]};
          shift_act = 1'b1;
        end
        MODE_LEFT: begin
          data_d    = {data_q[WIDTH-2:0], fill_l};
          shift_act = 1'b1;
        end
        MODE_LOAD: begin
          // Load restarts the word; a pending wrap is discarded.
          data_d = par_in;
          cnt_d  = '0;
        end
        default: begin
          data_d = data_q;
        end
      endcase
    end
    if (shift_act) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      data_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q         = data_q;
  assign ser_out_r = data_q[0];
  assign ser_out_l = data_q[WIDTH-1];
  assign shift_cnt = cnt_q;
  assign word_done = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - scoreboard bench for universal_shift_register (WIDTH=8)
module tb_universal_shift_register;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rstb;
  logic          en;
  logic [1:0]    mode;
  logic          ser_in_r;
  logic          ser_in_l;
  logic          rot;
  logic [W-1:0]  par_in;
  logic [W-1:0]  q;
  logic          ser_out_r;
  logic          ser_out_l;
  logic [CW-1:0] shift_cnt;
  logic          word_done;

  universal_shift_register #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .en        (en),
    .mode      (mode),
    .ser_in_r  (ser_in_r),
    .ser_in_l  (ser_in_l),
    .rot       (rot),
    .par_in    (par_in),
    .q         (q),
    .ser_out_r (ser_out_r),
    .ser_out_l (ser_out_l),
    .shift_cnt (shift_cnt),
    .word_done (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  q;
    logic [CW-1:0] cnt;
    logic          done;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  int step_no = 0;

  logic [W-1:0]  m_q   = '0;
  logic [CW-1:0] m_cnt = '0;
  logic          m_done = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one operation, push the model's expectation, then compare after the edge.
  task automatic step(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                      input logic r, input logic [W-1:0] p);
    exp_t x;
    logic in_r;
    logic in_l;
    logic sh;
    en = e; mode = m; ser_in_r = sr; ser_in_l = sl; rot = r; par_in = p;
    in_r = sr;
    in_l = sl;
`ifdef USR_ROTATE_EN
    if (r) begin
      in_r = m_q[0];
      in_l = m_q[W-1];
    end
`endif
    sh = 1'b0;
    m_done = 1'b0;
    if (e) begin
      if (m == 2'b01) begin m_q = {in_r, m_q[W-1:1]}; sh = 1'b1; end
      if (m == 2'b10) begin m_q = {m_q[W-2:0], in_l}; sh = 1'b1; end
      if (m == 2'b11) begin m_q = p; m_cnt = '0; end
    end
    if (sh) begin
      if (m_cnt == CW'(W - 1)) begin m_cnt = '0; m_done = 1'b1; end
      else m_cnt = m_cnt + 1'b1;
    end
    x.q = m_q; x.cnt = m_cnt; x.done = m_done;
    sb.push_back(x);
    @(posedge clk);
    #1;
    step_no++;
    x = sb.pop_front();
    check_val("q", 64'(q), 64'(x.q));
    check_val("shift_cnt", 64'(shift_cnt), 64'(x.cnt));
    check_val("word_done", 64'(word_done), 64'(x.done));
    check_val("ser_out_r", 64'(ser_out_r), 64'(x.q[0]));
    check_val("ser_out_l", 64'(ser_out_l), 64'(x.q[W-1]));
    if (word_done) n_done++;
  endtask

  task automatic do_reset();
    #2;
    rstb = 1'b0;
    #1;
    m_q = '0; m_cnt = '0; m_done = 1'b0;
    check_val("rst_q", 64'(q), 64'h0);
    check_val("rst_cnt", 64'(shift_cnt), 64'h0);
    check_val("rst_done", 64'(word_done), 64'h0);
    check_val("rst_sor", 64'(ser_out_r), 64'h0);
    check_val("rst_sol", 64'(ser_out_l), 64'h0);
    @(posedge clk);
    #1;
    rstb = 1'b1;
  endtask

  logic [W-1:0] a5_bits;
  logic [W-1:0] l_bits;
  int first_pulse;
  int second_pulse;
  int base;

  initial begin
    rstb = 1'b0; en = 1'b0; mode = 2'b00; ser_in_r = 1'b0; ser_in_l = 1'b0;
    rot = 1'b0; par_in = '0;
    #3;
    check_val("init_q", 64'(q), 64'h0);
    check_val("init_cnt", 64'(shift_cnt), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;

    // Reset mid-word: load A5, partial word, asynchronous reset discards count.
    step(1, 2'b11, 0, 0, 0, 8'hA5);
    check_val("load_a5", 64'(q), 64'hA5);
    step(1, 2'b01, 0, 0, 0, 8'h00);
    step(1, 2'b01, 0, 0, 0, 8'h00);
    step(1, 2'b01, 0, 0, 0, 8'h00);
    do_reset();

    // Load A5, shift out right with zero fill.
    step(1, 2'b11, 0, 0, 0, 8'hA5);
    a5_bits = 8'b10100101;
    n_done = 0;
    for (int i = 0; i < W; i++) begin
      check_val("a5_serout", 64'(ser_out_r), 64'(a5_bits[W-1-i]));
      step(1, 2'b01, 0, 0, 0, 8'h00);
    end
    check_val("a5_final_q", 64'(q), 64'h00);
    check_val("a5_final_done", 64'(word_done), 64'h1);
    check_val("a5_final_cnt", 64'(shift_cnt), 64'h0);
    step(1, 2'b00, 0, 0, 0, 8'h00);
    check_val("a5_done_drop", 64'(word_done), 64'h0);
    check_val("a5_pulses", 64'(n_done), 64'h1);

    // Left shift-in with en gaps (hold mode and en=0 both hold).
    step(1, 2'b11, 0, 0, 0, 8'h00);
    l_bits = 8'b11010010;
    n_done = 0;
    for (int i = 0; i < W; i++) begin
      step(1, 2'b10, 0, l_bits[W-1-i], 0, 8'h00);
      if (i < W - 1) begin
        step(0, 2'b10, 0, 1, 0, 8'hFF);
        step(1, 2'b00, 0, 1, 0, 8'hFF);
        if (i == 6) check_val("gap_no_done", 64'(n_done), 64'h0);
      end
    end
    check_val("left_q", 64'(q), 64'hD2);
    check_val("left_done", 64'(word_done), 64'h1);
    step(0, 2'b00, 0, 0, 0, 8'h00);
    check_val("left_pulses", 64'(n_done), 64'h1);

    // Load collision at count WIDTH-1, then 16 continuous shifts.
    step(1, 2'b11, 0, 0, 0, 8'h00);
    n_done = 0;
    for (int i = 0; i < W - 1; i++) step(1, 2'b01, 1, 0, 0, 8'h00);
    check_val("coll_cnt7", 64'(shift_cnt), 64'h7);
    step(1, 2'b11, 1, 0, 0, 8'h3C);
    check_val("coll_q", 64'(q), 64'h3C);
    check_val("coll_cnt", 64'(shift_cnt), 64'h0);
    check_val("coll_done", 64'(word_done), 64'h0);
    base = step_no;
    first_pulse = -1;
    second_pulse = -1;
    for (int i = 0; i < 2 * W; i++) begin
      step(1, (i % 2 == 0) ? 2'b01 : 2'b10, i[0], i[1], 0, 8'h00);
      if (word_done) begin
        if (first_pulse < 0) first_pulse = step_no - base;
        else second_pulse = step_no - base;
      end
    end
    check_val("coll_pulse1", 64'(first_pulse), 64'd8);
    check_val("coll_pulse2", 64'(second_pulse), 64'd16);
    check_val("coll_pulses", 64'(n_done), 64'd2);

    // Mixed direction from 81.
    step(1, 2'b11, 0, 0, 0, 8'h81);
    n_done = 0;
    for (int i = 0; i < 4; i++) step(1, 2'b01, 1, 0, 0, 8'h00);
    check_val("mix_mid_q", 64'(q), 64'hF8);
    check_val("mix_mid_cnt", 64'(shift_cnt), 64'h4);
    for (int i = 0; i < 4; i++) step(1, 2'b10, 1, 0, 0, 8'h00);
    check_val("mix_q", 64'(q), 64'h80);
    check_val("mix_done", 64'(word_done), 64'h1);

    // Rotate right with zero fill.
    step(1, 2'b11, 0, 0, 1, 8'h01);
    n_done = 0;
    for (int i = 0; i < W; i++) step(1, 2'b01, 0, 0, 1, 8'h00);
`ifdef USR_ROTATE_EN
    check_val("rot_q", 64'(q), 64'h01);
`else
    check_val("rot_q", 64'(q), 64'h00);
`endif
    check_val("rot_done", 64'(word_done), 64'h1);
    check_val("rot_pulses", 64'(n_done), 64'h1);

    // Random soak against the model.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 8'($urandom));

    check_val("sb_empty", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised universal shift register: the next generation of the team's 8-bit serial-in right-shift register. It supports hold, shift-right, shift-left and parallel load, each gated by an enable, and counts shifts so that a one-cycle `word_done` pulse marks every full word shifted since the last load. It is the common building block for the serialiser/deserialiser paths in the design: load-then-shift-out for TX, shift-in-then-read for RX. A compile-time option adds rotate behaviour.

## Interface
- `WIDTH`, default 8: register width in bits; legal range 2 to 64.
- `CW`, default `$clog2(WIDTH+1)`: width of the shift counter. Derived; not to be overridden.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rstb`  in  1  reset; asynchronous, active-low.
- `en`  in  1  enable; when low, all state holds, whatever `mode` is.
- `mode`  in  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `ser_in_r`  in  1  serial input; enters bit `WIDTH-1` on a right shift.
- `ser_in_l`  in  1  serial input; enters bit 0 on a left shift.
- `rot`  in  1  rotate request; acted on only when `USR_ROTATE_EN` is defined.
- `par_in`  in  WIDTH  parallel load data.
- `q`  out  WIDTH  register contents.
- `ser_out_r`  out  1  equals `q[0]`, the bit leaving on a right shift.
- `ser_out_l`  out  1  equals `q[WIDTH-1]`, the bit leaving on a left shift.
- `shift_cnt`  out  CW  number of shifts performed since the last load, reset or wrap.
- `word_done`  out  1  registered one-cycle pulse.

## Operation
- An operation is "active" only when `en`=1. Active mode 00 and `en`=0 behave identically: nothing changes.
- Shift right (01): `q <= {ser_in_r, q[WIDTH-1:1]}`.
- Shift left (10): `q <= {q[WIDTH-2:0], ser_in_l}`.
- Load (11): `q <= par_in`; `shift_cnt <= 0`.
- Shift counter:
  - Every active shift, in either direction, increments `shift_cnt`.
  - On the shift that would make the count equal `WIDTH`, `shift_cnt` wraps to 0 and `word_done` is set for one cycle.
  - Changing shift direction does not clear the count.
  - Hold does not change the count.
- `word_done` is 1 only in the cycle immediately following the wrapping shift edge; it is 0 in all other cycles.
- A load that coincides with `shift_cnt`=`WIDTH-1` does not pulse `word_done`. Load always wins because only one mode exists per cycle.
- `ser_out_r` and `ser_out_l` are combinational taps of `q`. They add no extra state.

## Timing
- Reset (`rstb` low): asynchronously forces `q`=0, `shift_cnt`=0 and `word_done`=0; therefore `ser_out_r`=`ser_out_l`=0.
- Reset is held for as long as `rstb` is low. The first operation is accepted on the first rising edge after `rstb` returns high.
- Reset asserted in the middle of a word discards the partial count. No `word_done` pulse is produced for that word.
- Latency: `q` and `shift_cnt` reflect an operation one edge after it is sampled. `word_done` is high during the cycle after the `WIDTH`-th shift edge.
- Back-to-back shifts with `en` held high:
  - produce one `word_done` pulse every `WIDTH` cycles;
  - the count sequence is 0..WIDTH-1 repeating, with no dead cycle.
- `en` low between shifts stretches the word; the count persists across the gap.

## Configuration
- Macro: `USR_ROTATE_EN`.
- Defined:
  - When `rot`=1 during an active shift, the serial input is replaced by the departing bit.
  - Right rotate: `q <= {q[0], q[WIDTH-1:1]}`. Left rotate: `q <= {q[WIDTH-2:0], q[WIDTH-1]}`.
  - Rotates count as shifts for `shift_cnt` and `word_done`.
  - `rot` has no effect during load or hold.
- Not defined:
  - `rot` is ignored; the port remains present so that both builds share the same instance template.
  - Shifts always take `ser_in_r` / `ser_in_l`.

## Test plan
All scenarios use `WIDTH`=8.
- Reset: drive `rstb`=0 mid-cycle after loading 8'hA5 -> `q`=8'h00, `shift_cnt`=0 and `word_done`=0 immediately, without waiting for a clock edge.
- Load then 8 right shifts with `ser_in_r`=0: load 8'hA5 -> `ser_out_r` sequence 1,0,1,0,0,1,0,1; `q`=8'h00 after the 8th shift; `word_done`=1 for exactly one cycle; `shift_cnt` back to 0.
- Left shift in with `en` toggling: 8 left shifts of bits 1,1,0,1,0,0,1,0 from `q`=0, with `en`=0 gaps between them -> final `q`=8'hD2; one `word_done` pulse after the 8th enabled shift only.
- Load collision: 7 shifts, then load 8'h3C -> no `word_done` pulse, `shift_cnt`=0, `q`=8'h3C. Then 16 continuous shifts -> `word_done` pulses exactly 8 and 16 cycles after the load.
- Mixed direction: from load 8'h81, shift right 4 times (`ser_in_r`=1), then left 4 times (`ser_in_l`=0) -> `q`=8'h80; `word_done` pulses after the 8th shift.
- Rotate (`USR_ROTATE_EN` defined): load 8'h01, then 8 right shifts with `rot`=1 -> `q` returns to 8'h01 and `word_done` pulses. Same stimulus with the macro undefined and `ser_in_r`=0 -> `q`=8'h00.
